aes_cbc_seq: RTL

- Sequencer in front of the single-block AES core.
- Owns the key-expansion handshake, keeps the CBC chaining value, and issues one block at a time to the core.
- Returns results over a valid/ready stream and runs a watchdog against a hung core.
- Sits between the host/DMA block stream and the AES datapath.

---
 rtl/aes_cbc_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/aes_cbc_seq.sv
// rtl/aes_cbc_seq.sv - CBC sequencer in front of a single-block AES core
// Handles key-expansion handshake, CBC chaining, one-block issue and core watchdog.
module aes_cbc_seq #(
    parameter int TMO_W   = 6,
    parameter int TMO_MAX = 40
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         key_new_i,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic         in_dec_i,
    input  logic         in_first_i,
    input  logic [127:0] in_iv_i,
    input  logic [127:0] in_data_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [127:0] out_data_o,
    output logic         out_err_o,
    output logic         ke_start_o,
    input  logic         ke_done_i,
    output logic         core_go_o,
    output logic         core_dec_o,
    output logic [127:0] core_din_o,
    input  logic         core_done_i,
    input  logic [127:0] core_dout_i,
    output logic         busy_o
);

    typedef enum logic [2:0] {IDLE, KEXP, ISSUE, WAIT, OUT} state_e;

    state_e           state_q, state_d;
    logic             key_ok_q, key_ok_d;
    logic             key_pend_q, key_pend_d;
    logic             dec_q, dec_d;
    logic             out_err_q, out_err_d;
    logic             ke_start_q, ke_start_d;
    logic [127:0]     chain_q, chain_d;
    logic [127:0]     ct_hold_q, ct_hold_d;
    logic [127:0]     core_din_q, core_din_d;
    logic [127:0]     out_data_q, out_data_d;
    logic [TMO_W-1:0] wdog_q, wdog_d;

    logic             in_rdy;
    logic             accept;
    logic [127:0]     c_sel;
    logic             kexp_expired;
    logic             wait_expired;

    assign in_rdy = (state_q == IDLE) & key_ok_q & ~key_pend_q & ~key_new_i;
    assign accept = in_vld_i & in_rdy;
    assign c_sel  = in_first_i ? in_iv_i : chain_q;

    // WAIT is entered one cycle after core_go and OUT is registered, so the
    // WAIT threshold is two short to put out_vld exactly TMO_MAX after core_go.
    assign kexp_expired = (wdog_q == TMO_W'(TMO_MAX - 1));
    assign wait_expired = (wdog_q == TMO_W'(TMO_MAX - 2));

    always_comb begin
        state_d    = state_q;
        key_ok_d   = key_ok_q;
        key_pend_d = key_pend_q;
        dec_d      = dec_q;
        out_err_d  = out_err_q;
        ke_start_d = 1'b0;
        chain_d    = chain_q;
        ct_hold_d  = ct_hold_q;
        core_din_d = core_din_q;
        out_data_d = out_data_q;
        wdog_d     = wdog_q;

        if ((state_q == KEXP || state_q == WAIT) && wdog_q != '1) begin
            wdog_d = wdog_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (key_new_i) begin
                    key_ok_d = 1'b0;
                end
                if (accept) begin
                    dec_d      = in_dec_i;
                    ct_hold_d  = in_data_i;
                    chain_d    = c_sel;
                    core_din_d = in_dec_i ? in_data_i : (in_data_i ^ c_sel);
                    state_d    = ISSUE;
                end else if (in_vld_i && !key_ok_q) begin
                    ke_start_d = 1'b1;
                    state_d    = KEXP;
                end
            end
            KEXP: begin
                if (ke_done_i) begin
                    key_ok_d = 1'b1;
                    state_d  = IDLE;
                end else if (kexp_expired) begin
                    key_ok_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (core_done_i) begin
                    if (dec_q) begin
                        out_data_d = core_dout_i ^ chain_q;
                        chain_d    = ct_hold_q;
                    end else begin
                        out_data_d = core_dout_i;
                        chain_d    = core_dout_i;
                    end
                    out_err_d = 1'b0;
                    state_d   = OUT;
                end else if (wait_expired) begin
                    out_data_d = '0;
                    out_err_d  = 1'b1;
                    key_ok_d   = 1'b0;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (out_rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A key change during a transaction is deferred until we are back in IDLE.
        if (state_q != IDLE && key_new_i) begin
            key_pend_d = 1'b1;
        end
        if (state_q != IDLE && state_d == IDLE && (key_pend_q || key_new_i)) begin
            key_ok_d   = 1'b0;
            key_pend_d = 1'b0;
        end

        if (state_d != state_q) begin
            wdog_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            key_ok_q   <= 1'b0;
            key_pend_q <= 1'b0;
            dec_q      <= 1'b0;
            out_err_q  <= 1'b0;
            ke_start_q <= 1'b0;
            chain_q    <= '0;
            ct_hold_q  <= '0;
            core_din_q <= '0;
            out_data_q <= '0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            key_ok_q   <= key_ok_d;
            key_pend_q <= key_pend_d;
            dec_q      <= dec_d;
            out_err_q  <= out_err_d;
            ke_start_q <= ke_start_d;
            chain_q    <= chain_d;
            ct_hold_q  <= ct_hold_d;
            core_din_q <= core_din_d;
            out_data_q <= out_data_d;
            wdog_q     <= wdog_d;
        end
    end

    assign in_rdy_o   = in_rdy;
    assign out_vld_o  = (state_q == OUT);
    assign out_data_o = out_data_q;
    assign out_err_o  = out_err_q;
    assign ke_start_o = ke_start_q;
    assign core_go_o  = (state_q == ISSUE);
    assign core_dec_o = dec_q;
    assign core_din_o = core_din_q;
    assign busy_o     = (state_q != IDLE);

endmodule
